// File: rtl/spart_tx.sv
// rtl/spart_tx.sv - SPART serial transmitter with 1-deep holding register
//
// Purpose:
//   Shifts bytes out on txd as start(0), DATA_W data bits LSB first, an
//   optional even-parity bit, then STOP_BITS stop(1) bits. One bit lasts
//   divisor_buffer+1 clk. A holding register in front of the shift register
//   lets the next byte start right after the previous frame's last stop clk.
//   Optional feature macro: SPART_TX_PARITY_EN (adds the parity bit).
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous reset, active-low
//   divisor_buffer in   baud divisor, bit period = divisor_buffer+1 clk
//   tx_load        in   write strobe, captures tx_data when tbr=1
//   tx_data        in   byte to send
//   txd            out  serial line, idles high, driven from a flop
//   tbr            out  holding register empty
//   tx_busy        out  frame in progress
//   tx_done        out  1-clk pulse in the final clk of the last stop bit
module spart_tx #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       divisor_buffer,
  input  logic              tx_load,
  input  logic [DATA_W-1:0] tx_data,
  output logic              txd,
  output logic              tbr,
  output logic              tx_busy,
  output logic              tx_done
);

`ifdef SPART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [15:0]       div_q, div_d;
  logic [15:0]       baud_q, baud_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              txd_q, txd_d;
`ifdef SPART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic bit_end;
  logic last_stop;
  logic take;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    div_d        = div_q;
    baud_d       = baud_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    txd_d        = 1'b1;
    take         = 1'b0;
`ifdef SPART_TX_PARITY_EN
    par_d        = par_q;
`endif

    bit_end   = (baud_q == 16'd0);
    last_stop = bit_end && (stop_cnt_q == 1'b0);

    // Every bit reloads the divisor latched at frame start, so a divisor
    // change mid-frame only shows up on the next frame.
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? div_q : baud_q - 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        take = hold_valid_q;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'(DATA_W - 1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 3'd0) begin
`ifdef SPART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d    = S_STOP;
            stop_cnt_d = 1'(STOP_BITS - 1);
`endif
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
      end
`ifdef SPART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          stop_cnt_d = 1'(STOP_BITS - 1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == 1'b0) begin
            // Chain straight into the next start bit when a byte is waiting.
            if (hold_valid_q) begin
              take = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      state_d      = S_START;
      shift_d      = hold_q;
      hold_valid_d = 1'b0;
      div_d        = divisor_buffer;
      baud_d       = divisor_buffer;
`ifdef SPART_TX_PARITY_EN
      par_d        = ^hold_q;
`endif
    end

    // Load only into an empty hold; take requires a full hold, so the two
    // never collide on the same edge.
    if (tx_load && !hold_valid_q) begin
      hold_d       = tx_data;
      hold_valid_d = 1'b1;
    end

    // txd is registered from the next-state view so the line changes on the
    // same edge as the state and never glitches.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef SPART_TX_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      div_q        <= '0;
      baud_q       <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      txd_q        <= 1'b1;
`ifdef SPART_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      div_q        <= div_d;
      baud_q       <= baud_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      txd_q        <= txd_d;
`ifdef SPART_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign txd     = txd_q;
  assign tbr     = !hold_valid_q;
  assign tx_busy = (state_q != S_IDLE);
  assign tx_done = (state_q == S_STOP) && last_stop;

endmodule

// File: tb/tb_spart_tx.sv
// tb/tb_spart_tx.sv - self-checking bench for spart_tx
module tb_spart_tx;

`ifdef SPART_TX_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div_a, div_b;
  logic        load_a, load_b;
  logic [7:0]  data_a, data_b;
  logic        txd_a, tbr_a, busy_a, done_a;
  logic        txd_b, tbr_b, busy_b, done_b;

  int errors = 0;
  int checks = 0;
  int exp_txd[$];
  int exp_done[$];

  always #5 clk = ~clk;

  spart_tx #(.DATA_W(8), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .divisor_buffer(div_a), .tx_load(load_a), .tx_data(data_a),
    .txd(txd_a), .tbr(tbr_a), .tx_busy(busy_a), .tx_done(done_a)
  );

  spart_tx #(.DATA_W(8), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .divisor_buffer(div_b), .tx_load(load_b), .tx_data(data_b),
    .txd(txd_b), .tbr(tbr_b), .tx_busy(busy_b), .tx_done(done_b)
  );

  // Reference: list the frame's bit levels, then hold each for div+1 clocks.
  function automatic void push_frame(input logic [7:0] d, input int div, input int nstop);
    int bits[$];
    bits.push_back(0);
    for (int k = 0; k < 8; k++) bits.push_back(int'(d[k]));
    if (PE == 1) bits.push_back(int'(^d));
    for (int k = 0; k < nstop; k++) bits.push_back(1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c <= div; c++) begin
        exp_txd.push_back(bits[b]);
        exp_done.push_back((b == bits.size() - 1 && c == div) ? 1 : 0);
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL reset_txd_a: got %b want 1", txd_a); end
    checks++; if (tbr_a !== 1'b1) begin errors++; $display("FAIL reset_tbr_a: got %b want 1", tbr_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done_a: got %b want 0", done_a); end
    checks++; if (txd_b !== 1'b1) begin errors++; $display("FAIL reset_txd_b: got %b want 1", txd_b); end
    checks++; if (tbr_b !== 1'b1) begin errors++; $display("FAIL reset_tbr_b: got %b want 1", tbr_b); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
    checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL reset_done_b: got %b want 0", done_b); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (txd_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: txd=%b busy=%b want 1/0", txd_a, busy_a);
    end
  endtask

  task automatic test_single();
    logic [7:0] d;
    int dv, n;
    for (int t = 0; t < 4; t++) begin
      d  = (t == 0) ? 8'hA5 : 8'($urandom);
      dv = (t == 0) ? 3 : int'($urandom_range(0, 5));
      exp_txd.delete(); exp_done.delete();
      push_frame(d, dv, 1);
      div_a = 16'(dv); data_a = d; load_a = 1'b1;
      @(negedge clk);
      load_a = 1'b0;
      checks++; if (tbr_a !== 1'b0 || txd_a !== 1'b1) begin
        errors++; $display("FAIL single_after_load: tbr=%b txd=%b want 0/1", tbr_a, txd_a);
      end
      n = exp_txd.size();
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        checks++; if (txd_a !== 1'(exp_txd[i])) begin
          errors++; $display("FAIL single_txd d=%h clk%0d: got %b want %0d", d, i, txd_a, exp_txd[i]);
        end
        checks++; if (done_a !== 1'(exp_done[i])) begin
          errors++; $display("FAIL single_done d=%h clk%0d: got %b want %0d", d, i, done_a, exp_done[i]);
        end
        checks++; if (busy_a !== 1'b1 || tbr_a !== 1'b1) begin
          errors++; $display("FAIL single_busy_tbr clk%0d: busy=%b tbr=%b want 1/1", i, busy_a, tbr_a);
        end
      end
      @(negedge clk);
      checks++; if (txd_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
        errors++; $display("FAIL single_end: txd=%b busy=%b done=%b want 1/0/0", txd_a, busy_a, done_a);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d0, d1;
    int dv, n;
    for (int t = 0; t < 2; t++) begin
      d0 = (t == 0) ? 8'h55 : 8'($urandom);
      d1 = (t == 0) ? 8'h0F : 8'($urandom);
      dv = (t == 0) ? 3 : int'($urandom_range(0, 4));
      exp_txd.delete(); exp_done.delete();
      push_frame(d0, dv, 1);
      push_frame(d1, dv, 1);
      div_a = 16'(dv); data_a = d0; load_a = 1'b1;
      @(negedge clk);
      load_a = 1'b0;
      n = exp_txd.size();
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        if (i == 0) begin
          checks++; if (tbr_a !== 1'b1) begin errors++; $display("FAIL b2b_tbr_rise: got %b want 1", tbr_a); end
          load_a = 1'b1; data_a = d1;
        end else if (i == 1) begin
          checks++; if (tbr_a !== 1'b0) begin errors++; $display("FAIL b2b_tbr_full: got %b want 0", tbr_a); end
          data_a = 8'h12;   // held while the hold is full: must be ignored
        end else if (i == 6) begin
          load_a = 1'b0;
        end
        checks++; if (txd_a !== 1'(exp_txd[i])) begin
          errors++; $display("FAIL b2b_txd clk%0d: got %b want %0d", i, txd_a, exp_txd[i]);
        end
        checks++; if (done_a !== 1'(exp_done[i])) begin
          errors++; $display("FAIL b2b_done clk%0d: got %b want %0d", i, done_a, exp_done[i]);
        end
        checks++; if (busy_a !== 1'b1) begin
          errors++; $display("FAIL b2b_busy clk%0d: got %b want 1", i, busy_a);
        end
      end
      @(negedge clk);
      checks++; if (txd_a !== 1'b1 || busy_a !== 1'b0 || tbr_a !== 1'b1) begin
        errors++; $display("FAIL b2b_end: txd=%b busy=%b tbr=%b want 1/0/1", txd_a, busy_a, tbr_a);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_txd.delete(); exp_done.delete();
    push_frame(8'hFF, 3, 1);
    div_a = 16'd3; data_a = 8'hFF; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 2) begin load_a = 1'b1; data_a = 8'h3C; end
      if (i == 3) load_a = 1'b0;
      checks++; if (txd_a !== 1'(exp_txd[i])) begin
        errors++; $display("FAIL rmid_txd clk%0d: got %b want %0d", i, txd_a, exp_txd[i]);
      end
    end
    checks++; if (tbr_a !== 1'b0) begin errors++; $display("FAIL rmid_hold_full: got %b want 0", tbr_a); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL rmid_txd_reset: got %b want 1", txd_a); end
    checks++; if (tbr_a !== 1'b1) begin errors++; $display("FAIL rmid_tbr_reset: got %b want 1", tbr_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rmid_busy_reset: got %b want 0", busy_a); end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++; if (txd_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++; $display("FAIL rmid_quiet clk%0d: txd=%b done=%b busy=%b want 1/0/0", i, txd_a, done_a, busy_a);
      end
    end
  endtask

  task automatic test_div0_stop2();
    logic [7:0] d1;
    int n;
    d1 = 8'($urandom);
    exp_txd.delete(); exp_done.delete();
    push_frame(8'h80, 0, 2);
    push_frame(d1, 7, 2);
    div_b = 16'd0; data_b = 8'h80; load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    n = exp_txd.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 2) div_b = 16'd7;
      if (i == 3) begin load_b = 1'b1; data_b = d1; end
      if (i == 4) load_b = 1'b0;
      checks++; if (txd_b !== 1'(exp_txd[i])) begin
        errors++; $display("FAIL div0_txd clk%0d: got %b want %0d", i, txd_b, exp_txd[i]);
      end
      checks++; if (done_b !== 1'(exp_done[i])) begin
        errors++; $display("FAIL div0_done clk%0d: got %b want %0d", i, done_b, exp_done[i]);
      end
    end
    @(negedge clk);
    checks++; if (txd_b !== 1'b1 || busy_b !== 1'b0) begin
      errors++; $display("FAIL div0_end: txd=%b busy=%b want 1/0", txd_b, busy_b);
    end
  endtask

`ifdef SPART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] d;
    logic       pbit;
    int         ndone;
    for (int t = 0; t < 2; t++) begin
      d    = (t == 0) ? 8'hA5 : 8'h07;
      pbit = (t == 0) ? 1'b0 : 1'b1;
      ndone = 0;
      div_a = 16'd3; data_a = d; load_a = 1'b1;
      @(negedge clk);
      load_a = 1'b0;
      for (int i = 0; i < 44; i++) begin
        @(negedge clk);
        if (done_a === 1'b1) ndone++;
        if (i >= 36 && i <= 39) begin
          checks++; if (txd_a !== pbit) begin
            errors++; $display("FAIL parity_bit d=%h clk%0d: got %b want %b", d, i, txd_a, pbit);
          end
        end
        if (i == 43) begin
          checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL parity_done_at_44: got %b want 1", done_a); end
        end
      end
      checks++; if (ndone != 1) begin errors++; $display("FAIL parity_done_count: got %0d want 1", ndone); end
      @(negedge clk);
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL parity_end_busy: got %b want 0", busy_a); end
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    div_a = 16'd0; div_b = 16'd0;
    load_a = 1'b0; load_b = 1'b0;
    data_a = 8'h00; data_b = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_div0_stop2();
`ifdef SPART_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
